sobel_window_ctrl: RTL and testbench

Sequencing controller for the line-buffer/window datapath in front of the Sobel kernel. It tracks the raster position of every accepted pixel and issues the shift strobe to the delay-line buffers. It decides which accepted pixels complete a full KERNEL_P x KERNEL_P window and produces a backpressured output stream of window-valid events with end-of-frame marking. Sits between the pixel source and the line buffers/kernel, replacing ad-hoc valid gating.

---
 rtl/sobel_window_ctrl_if.sv | 39 +++
 rtl/sobel_window_ctrl.sv | 130 +++++++++++++
 tb/tb_sobel_window_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_ctrl_if.sv
// sobel_window_ctrl_if
//   Pixel-side and window-side handshake bundle for sobel_window_ctrl.
//   CW / RW must equal the controller's column / row counter widths
//   ($clog2 of image width / height).
//
//   valid_i    pixel source -> ctrl   upstream pixel valid
//   ready_o    ctrl -> pixel source   upstream ready
//   shift_en_o ctrl -> line buffers   accept strobe
//   col_o      ctrl -> line buffers   column of the pixel being accepted
//   row_o      ctrl -> line buffers   row of the pixel being accepted
//   valid_o    ctrl -> kernel         window-valid event
//   ready_i    kernel -> ctrl         downstream ready
//   last_o     ctrl -> kernel         final window of the frame
//
//   slave  : controller view
//   master : source/sink (testbench) view
interface sobel_window_ctrl_if #(
  parameter int CW = 10,
  parameter int RW = 9
);
  logic          valid_i;
  logic          ready_o;
  logic          shift_en_o;
  logic [CW-1:0] col_o;
  logic [RW-1:0] row_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;

  modport slave (
    input  valid_i, ready_i,
    output ready_o, shift_en_o, col_o, row_o, valid_o, last_o
  );

  modport master (
    output valid_i, ready_i,
    input  ready_o, shift_en_o, col_o, row_o, valid_o, last_o
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl
//   Sequencing controller for the line-buffer / window datapath ahead of
//   the Sobel kernel. Tracks the raster position of every accepted pixel,
//   strobes the line buffers, and emits one backpressured window-valid
//   event for each accepted pixel that completes a full KERNEL_P x
//   KERNEL_P window, marking the final window of the frame with last_o.
//
//   clk_i        clock
//   rstn_i       synchronous active-low reset
//   clear_i      synchronous frame abort (same effect as reset)
//   bus          handshake bundle (slave modport), see sobel_window_ctrl_if
//   busy_o       controller is inside a frame (state != IDLE)
//   frame_done_o one-cycle pulse after the last pixel of a frame is accepted
module sobel_window_ctrl #(
  parameter int IMG_W_P  = 640,
  parameter int IMG_H_P  = 480,
  parameter int KERNEL_P = 3
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               clear_i,
  sobel_window_ctrl_if.slave bus,
  output logic               busy_o,
  output logic               frame_done_o
);

  localparam int CW = $clog2(IMG_W_P);
  localparam int RW = $clog2(IMG_H_P);

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W_P - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KERNEL_P - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H_P - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(KERNEL_P - 2);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KERNEL_P - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_valid;
  logic          r_last;
  logic          r_frame_done;

  logic          w_sync_rst;
  logic          w_ready;
  logic          w_accept;
  logic          w_col_end;
  logic          w_frame_end;
  logic          w_window;

  // Reset and frame abort act identically on all state.
  assign w_sync_rst = ~rstn_i | clear_i;

  // Single output slot: a new pixel may be taken whenever the slot is empty
  // or is being drained this cycle. clear_i blocks the accept that cycle.
  assign w_ready     = (~r_valid | bus.ready_i) & ~clear_i;
  assign w_accept    = bus.valid_i & w_ready;
  assign w_col_end   = (r_col == COL_LAST);
  assign w_frame_end = w_col_end & (r_row == ROW_LAST);
  assign w_window    = w_accept & (r_col >= COL_FIRST_WIN) & (r_row >= ROW_FIRST_WIN);

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk_i) begin
    if (w_sync_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_sync_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FILL covers the first KERNEL_P-1 lines, where no window can complete.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_FILL;
      ST_FILL: if (w_accept && w_col_end && (r_row == ROW_FILL_LAST)) w_state_next = ST_RUN;
      ST_RUN:  if (w_accept && w_frame_end) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output slot. A window load always wins over a drain; since loads only
  // happen on an accept, a held (stalled) event is never overwritten.
  always_ff @(posedge clk_i) begin
    if (w_sync_rst) begin
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept & w_frame_end;
      if (w_window) begin
        r_valid <= 1'b1;
        r_last  <= w_frame_end;
      end else if (bus.ready_i) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign bus.ready_o    = w_ready;
  assign bus.shift_en_o = w_accept;
  assign bus.col_o      = r_col;
  assign bus.row_o      = r_row;
  assign bus.valid_o    = r_valid;
  assign bus.last_o     = r_last;
  assign busy_o         = (r_state != ST_IDLE);
  assign frame_done_o   = r_frame_done;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl
//   Directed bench for sobel_window_ctrl. dut_a uses a 4x3 image, dut_b a
//   5x4 image, both with a 3x3 kernel. Inputs change 1 time unit after the
//   rising edge and outputs are sampled 2 units later.
module tb_sobel_window_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic clear;
  logic busy_a, fd_a, busy_b, fd_b;
  int   checks = 0;
  int   errors = 0;

  sobel_window_ctrl_if #(.CW(2), .RW(2)) bus_a ();
  sobel_window_ctrl_if #(.CW(3), .RW(2)) bus_b ();

  sobel_window_ctrl #(.IMG_W_P(4), .IMG_H_P(3), .KERNEL_P(3)) dut_a (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .clear_i      (clear),
    .bus          (bus_a),
    .busy_o       (busy_a),
    .frame_done_o (fd_a)
  );

  sobel_window_ctrl #(.IMG_W_P(5), .IMG_H_P(4), .KERNEL_P(3)) dut_b (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .clear_i      (clear),
    .bus          (bus_b),
    .busy_o       (busy_b),
    .frame_done_o (fd_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear = 1'b0;
    bus_a.valid_i = 1'b0;
    bus_a.ready_i = 1'b1;
    bus_b.valid_i = 1'b0;
    bus_b.ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    #2;
    checks++;
    if ({bus_a.valid_o, bus_a.last_o, busy_a, fd_a, bus_a.shift_en_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs_a: got %b expected 00000",
               {bus_a.valid_o, bus_a.last_o, busy_a, fd_a, bus_a.shift_en_o});
    end
    checks++;
    if ({bus_a.row_o, bus_a.col_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_pos_a: got row %0d col %0d expected 0 0", bus_a.row_o, bus_a.col_o);
    end
    checks++;
    if (bus_a.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_a: got %b expected 1", bus_a.ready_o);
    end
    checks++;
    if ({bus_b.valid_o, bus_b.last_o, busy_b, fd_b} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outs_b: got %b expected 0000", {bus_b.valid_o, bus_b.last_o, busy_b, fd_b});
    end
    $display("reset released");
    tick();
  endtask

  // One 12-pixel frame at full throughput. Windows complete at pixels
  // (2,2) and (3,2), i.e. accept indices 10 and 11.
  task automatic test_full_frame();
    int shifts = 0;
    int wins = 0;
    int lasts = 0;
    int dones = 0;
    bus_a.valid_i = 1'b1;
    bus_a.ready_i = 1'b1;
    for (int n = 0; n < 14; n++) begin
      if (n == 12) bus_a.valid_i = 1'b0;
      #2;
      checks++;
      if (bus_a.shift_en_o !== (n < 12)) begin
        errors++;
        $display("FAIL frame_shift n=%0d: got %b expected %b", n, bus_a.shift_en_o, n < 12);
      end
      if (n < 12) begin
        checks++;
        if (bus_a.col_o !== 2'(n % 4) || bus_a.row_o !== 2'(n / 4)) begin
          errors++;
          $display("FAIL frame_pos n=%0d: got col %0d row %0d expected col %0d row %0d",
                   n, bus_a.col_o, bus_a.row_o, n % 4, n / 4);
        end
      end
      checks++;
      if (bus_a.valid_o !== (n == 11 || n == 12) || bus_a.last_o !== (n == 12)) begin
        errors++;
        $display("FAIL frame_valid n=%0d: got valid %b last %b expected %b %b",
                 n, bus_a.valid_o, bus_a.last_o, (n == 11 || n == 12), n == 12);
      end
      checks++;
      if (busy_a !== (n >= 1 && n <= 11) || fd_a !== (n == 12)) begin
        errors++;
        $display("FAIL frame_busy n=%0d: got busy %b done %b expected %b %b",
                 n, busy_a, fd_a, (n >= 1 && n <= 11), n == 12);
      end
      if (bus_a.shift_en_o) shifts++;
      if (bus_a.valid_o && bus_a.ready_i) begin
        wins++;
        if (bus_a.last_o) lasts++;
        $display("A window %0d last=%b", wins, bus_a.last_o);
      end
      if (fd_a) dones++;
      tick();
    end
    checks++;
    if (shifts != 12 || wins != 2 || lasts != 1 || dones != 1) begin
      errors++;
      $display("FAIL frame_totals: got shifts %0d wins %0d lasts %0d dones %0d expected 12 2 1 1",
               shifts, wins, lasts, dones);
    end
  endtask

  // Stall the first window, then release and collect the second.
  task automatic test_backpressure();
    bus_a.valid_i = 1'b1;
    bus_a.ready_i = 1'b1;
    for (int n = 0; n < 11; n++) begin
      #2;
      checks++;
      if (bus_a.shift_en_o !== 1'b1) begin
        errors++;
        $display("FAIL bp_fill n=%0d: got shift %b expected 1", n, bus_a.shift_en_o);
      end
      tick();
    end
    bus_a.ready_i = 1'b0;
    for (int h = 0; h < 5; h++) begin
      #2;
      checks++;
      if ({bus_a.valid_o, bus_a.last_o, bus_a.ready_o, bus_a.shift_en_o} !== 4'b1000) begin
        errors++;
        $display("FAIL bp_hold h=%0d: got valid/last/ready/shift %b expected 1000", h,
                 {bus_a.valid_o, bus_a.last_o, bus_a.ready_o, bus_a.shift_en_o});
      end
      tick();
    end
    bus_a.ready_i = 1'b1;
    #2;
    checks++;
    if ({bus_a.shift_en_o, bus_a.valid_o, bus_a.last_o} !== 3'b110 ||
        bus_a.col_o !== 2'd3 || bus_a.row_o !== 2'd2) begin
      errors++;
      $display("FAIL bp_release: got shift/valid/last %b col %0d row %0d expected 110 3 2",
               {bus_a.shift_en_o, bus_a.valid_o, bus_a.last_o}, bus_a.col_o, bus_a.row_o);
    end
    $display("A window 1 last=%b (after stall)", bus_a.last_o);
    tick();
    bus_a.valid_i = 1'b0;
    #2;
    checks++;
    if ({bus_a.valid_o, bus_a.last_o, fd_a, bus_a.shift_en_o} !== 4'b1110) begin
      errors++;
      $display("FAIL bp_last: got valid/last/done/shift %b expected 1110",
               {bus_a.valid_o, bus_a.last_o, fd_a, bus_a.shift_en_o});
    end
    $display("A window 2 last=%b", bus_a.last_o);
    tick();
    #2;
    checks++;
    if ({bus_a.valid_o, busy_a} !== 2'b00) begin
      errors++;
      $display("FAIL bp_drain: got valid/busy %b expected 00", {bus_a.valid_o, busy_a});
    end
    tick();
  endtask

  // Abort at pixel (1,1), then run a clean frame.
  task automatic test_clear();
    int wins = 0;
    int lasts = 0;
    int dones = 0;
    bus_a.valid_i = 1'b1;
    bus_a.ready_i = 1'b1;
    repeat (5) tick();
    clear = 1'b1;
    #2;
    checks++;
    if ({bus_a.shift_en_o, bus_a.ready_o, busy_a} !== 3'b001 ||
        bus_a.col_o !== 2'd1 || bus_a.row_o !== 2'd1) begin
      errors++;
      $display("FAIL clear_cycle: got shift/ready/busy %b col %0d row %0d expected 001 1 1",
               {bus_a.shift_en_o, bus_a.ready_o, busy_a}, bus_a.col_o, bus_a.row_o);
    end
    tick();
    clear = 1'b0;
    bus_a.valid_i = 1'b0;
    #2;
    checks++;
    if ({busy_a, bus_a.valid_o, bus_a.row_o, bus_a.col_o} !== 6'b0) begin
      errors++;
      $display("FAIL clear_after: got busy %b valid %b row %0d col %0d expected 0 0 0 0",
               busy_a, bus_a.valid_o, bus_a.row_o, bus_a.col_o);
    end
    tick();
    bus_a.valid_i = 1'b1;
    for (int n = 0; n < 14; n++) begin
      if (n == 12) bus_a.valid_i = 1'b0;
      #2;
      if (n < 12) begin
        checks++;
        if (bus_a.shift_en_o !== 1'b1 || bus_a.col_o !== 2'(n % 4) || bus_a.row_o !== 2'(n / 4)) begin
          errors++;
          $display("FAIL clear_frame_pos n=%0d: got shift %b col %0d row %0d expected 1 %0d %0d",
                   n, bus_a.shift_en_o, bus_a.col_o, bus_a.row_o, n % 4, n / 4);
        end
      end
      if (bus_a.valid_o && bus_a.ready_i) begin
        wins++;
        if (bus_a.last_o) lasts++;
        $display("A window %0d last=%b (post-clear)", wins, bus_a.last_o);
      end
      if (fd_a) dones++;
      tick();
    end
    checks++;
    if (wins != 2 || lasts != 1 || dones != 1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL clear_totals: got wins %0d lasts %0d dones %0d busy %b expected 2 1 1 0",
               wins, lasts, dones, busy_a);
    end
  endtask

  // Reset while a stalled window is pending in the RUN state.
  task automatic test_reset_mid_run();
    bus_a.valid_i = 1'b1;
    bus_a.ready_i = 1'b1;
    repeat (11) tick();
    bus_a.ready_i = 1'b0;
    rstn = 1'b0;
    #2;
    checks++;
    if ({bus_a.valid_o, busy_a} !== 2'b11) begin
      errors++;
      $display("FAIL rst_run_pre: got valid/busy %b expected 11", {bus_a.valid_o, busy_a});
    end
    tick();
    rstn = 1'b1;
    bus_a.ready_i = 1'b1;
    bus_a.valid_i = 1'b0;
    #2;
    checks++;
    if ({bus_a.valid_o, bus_a.last_o, busy_a, fd_a, bus_a.row_o, bus_a.col_o} !== 8'b0) begin
      errors++;
      $display("FAIL rst_run_post: got valid %b last %b busy %b done %b row %0d col %0d expected all 0",
               bus_a.valid_o, bus_a.last_o, busy_a, fd_a, bus_a.row_o, bus_a.col_o);
    end
    checks++;
    if (bus_a.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_run_ready: got %b expected 1", bus_a.ready_o);
    end
    tick();
    #2;
    checks++;
    if (fd_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_done: got %b expected 0", fd_a);
    end
    tick();
  endtask

  // Three back-to-back 5x4 frames with random gaps and backpressure.
  // Each frame has 3x2 = 6 windows; the final one is at pixel (4,3).
  task automatic test_random_frames();
    logic q[$];
    int   acc = 0;
    int   wins = 0;
    int   lasts = 0;
    int   dones = 0;
    bit   done = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_last = 1'b0;
    logic exp_ready;
    logic exp_last;
    int   ecol, erow;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      bus_b.valid_i = (acc < 60) ? ($urandom_range(0, 3) != 0) : 1'b0;
      bus_b.ready_i = ($urandom_range(0, 2) != 0);
      #2;
      exp_ready = !bus_b.valid_o || bus_b.ready_i;
      checks++;
      if (bus_b.ready_o !== exp_ready || bus_b.shift_en_o !== (bus_b.valid_i && exp_ready)) begin
        errors++;
        $display("FAIL rnd_handshake cyc=%0d: got ready %b shift %b expected %b %b",
                 cyc, bus_b.ready_o, bus_b.shift_en_o, exp_ready, bus_b.valid_i && exp_ready);
      end
      if (prev_stall) begin
        checks++;
        if (bus_b.valid_o !== 1'b1 || bus_b.last_o !== prev_last) begin
          errors++;
          $display("FAIL rnd_hold cyc=%0d: got valid %b last %b expected 1 %b",
                   cyc, bus_b.valid_o, bus_b.last_o, prev_last);
        end
      end
      if (bus_b.valid_o && bus_b.ready_i) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra_window cyc=%0d: got window expected none", cyc);
        end else begin
          exp_last = q.pop_front();
          if (bus_b.last_o !== exp_last) begin
            errors++;
            $display("FAIL rnd_last cyc=%0d: got %b expected %b", cyc, bus_b.last_o, exp_last);
          end
        end
        wins++;
        if (bus_b.last_o) lasts++;
        $display("B window %0d last=%b", wins, bus_b.last_o);
      end
      if (bus_b.shift_en_o) begin
        ecol = acc % 5;
        erow = (acc / 5) % 4;
        checks++;
        if (bus_b.col_o !== 3'(ecol) || bus_b.row_o !== 2'(erow)) begin
          errors++;
          $display("FAIL rnd_pos acc=%0d: got col %0d row %0d expected col %0d row %0d",
                   acc, bus_b.col_o, bus_b.row_o, ecol, erow);
        end
        if (ecol >= 2 && erow >= 2) q.push_back(ecol == 4 && erow == 3);
        acc++;
      end
      if (fd_b) dones++;
      prev_stall = bus_b.valid_o && !bus_b.ready_i;
      prev_last = bus_b.last_o;
      tick();
      if (acc == 60 && q.size() == 0 && !bus_b.valid_o) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rnd_timeout: got %0d accepts %0d windows expected 60 18", acc, wins);
    end
    checks++;
    if (wins != 18 || lasts != 3 || dones != 3 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL rnd_totals: got wins %0d lasts %0d dones %0d busy %b expected 18 3 3 0",
               wins, lasts, dones, busy_b);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_clear();
    test_reset_mid_run();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
